// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - level/round sequencer for a timed game.
// Counts down a per-level timer, requests a judge verdict, advances, retries or ends the game.
module level_sequencer #(
  parameter int TICK_DIV        = 100000000,
  parameter int ROUND_TIME      = 30,
  parameter int MAX_LEVEL       = 15,
  parameter int VERDICT_TIMEOUT = 4
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       start,
  input  logic       roundDone,
  input  logic       incLevel,
  input  logic       lose,
  output logic       levelComplete,
  output logic [3:0] level,
  output logic [5:0] timeLeft,
  output logic       playing,
  output logic       gameOver,
  output logic       win,
  output logic       newLevel
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]      TIME_INIT  = 6'(ROUND_TIME);
  localparam logic [3:0]      LVL_MAX    = 4'(MAX_LEVEL);
  localparam logic [3:0]      VCNT_LAST  = 4'(VERDICT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_JUDGE, S_WAIT, S_OVER, S_WIN
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    level_q, level_d;
  logic [5:0]    time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    vcnt_q, vcnt_d;
  logic          lc_q, lc_d;
  logic          new_q, new_d;
  logic          playing_q, gameover_q, win_q;
  logic          enter_play;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    time_d     = time_q;
    presc_d    = '0;
    vcnt_d     = vcnt_q;
    lc_d       = 1'b0;
    new_d      = 1'b0;
    enter_play = 1'b0;

    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) begin
          enter_play = 1'b1;
          level_d    = 4'd1;
        end
      end
      S_PLAY: begin
        // A finished round beats a same-cycle expiry; the timer freezes here.
        if (roundDone) begin
          state_d = S_JUDGE;
          lc_d    = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
          if (time_q <= 6'd1) begin
            time_d  = 6'd0;
            state_d = S_OVER;
          end else begin
            time_d = time_q - 6'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_JUDGE: begin
        state_d = S_WAIT;
        vcnt_d  = 4'd0;
      end
      S_WAIT: begin
        if (lose) begin
          state_d = S_OVER;
        end else if (incLevel) begin
          if (level_q < LVL_MAX) begin
            level_d    = level_q + 4'd1;
            enter_play = 1'b1;
          end else begin
            state_d = S_WIN;
          end
        end else if (vcnt_q == VCNT_LAST) begin
          enter_play = 1'b1;
        end else begin
          vcnt_d = vcnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_play) begin
      state_d = S_PLAY;
      time_d  = TIME_INIT;
      new_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      level_q    <= 4'd1;
      time_q     <= TIME_INIT;
      presc_q    <= '0;
      vcnt_q     <= 4'd0;
      lc_q       <= 1'b0;
      new_q      <= 1'b0;
      playing_q  <= 1'b0;
      gameover_q <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      vcnt_q     <= vcnt_d;
      lc_q       <= lc_d;
      new_q      <= new_d;
      playing_q  <= (state_d == S_PLAY);
      gameover_q <= (state_d == S_OVER);
      win_q      <= (state_d == S_WIN);
    end
  end

  assign levelComplete = lc_q;
  assign level         = level_q;
  assign timeLeft      = time_q;
  assign playing       = playing_q;
  assign gameOver      = gameover_q;
  assign win           = win_q;
  assign newLevel      = new_q;

endmodule

// File: tb/tb_level_sequencer.sv
// tb/tb_level_sequencer.sv - directed bench for level_sequencer with a cycle-level reference model.
module tb_level_sequencer;

  localparam int TD = 4;
  localparam int RT = 3;
  localparam int ML = 3;
  localparam int VT = 4;

  logic       clk = 1'b0;
  logic       rst, start, roundDone, incLevel, lose;
  logic       levelComplete, playing, gameOver, win, newLevel;
  logic [3:0] level;
  logic [5:0] timeLeft;

  int n_cmp = 0;
  int n_bad = 0;

  level_sequencer #(
    .TICK_DIV(TD), .ROUND_TIME(RT), .MAX_LEVEL(ML), .VERDICT_TIMEOUT(VT)
  ) dut (
    .Clk100M(clk), .Reset(rst), .start(start), .roundDone(roundDone),
    .incLevel(incLevel), .lose(lose), .levelComplete(levelComplete),
    .level(level), .timeLeft(timeLeft), .playing(playing),
    .gameOver(gameOver), .win(win), .newLevel(newLevel)
  );

  always #5 clk = ~clk;

  // Model: time remaining is derived from cycles spent in the current attempt.
  typedef enum int {M_IDLE, M_PLAY, M_JUDGE, M_WAIT, M_OVER, M_WIN} mphase_t;
  mphase_t m_ph = M_IDLE;
  int      m_level = 1, m_ticks = 0, m_tleft = RT, m_wait = 0;
  bit      m_new = 0, m_valid = 0;

  always @(posedge clk) begin
    mphase_t ph;
    int lv, tk, tl, w;
    bit nw, go;
    ph = m_ph; lv = m_level; tk = m_ticks; tl = m_tleft; w = m_wait;
    nw = 0; go = 0;
    if (rst) begin
      ph = M_IDLE; lv = 1; tl = RT; tk = 0; w = 0;
    end else begin
      case (m_ph)
        M_IDLE, M_OVER, M_WIN: if (start) begin go = 1; lv = 1; end
        M_PLAY: begin
          if (roundDone) ph = M_JUDGE;
          else begin
            tk = tk + 1;
            tl = RT - tk / TD;
            if (tk == RT * TD) ph = M_OVER;
          end
        end
        M_JUDGE: begin ph = M_WAIT; w = 0; end
        M_WAIT: begin
          if (lose) ph = M_OVER;
          else if (incLevel) begin
            if (lv < ML) begin lv = lv + 1; go = 1; end
            else ph = M_WIN;
          end else begin
            w = w + 1;
            if (w == VT) go = 1;
          end
        end
        default: ph = M_IDLE;
      endcase
    end
    if (go) begin ph = M_PLAY; tk = 0; tl = RT; nw = 1; end
    m_ph <= ph; m_level <= lv; m_ticks <= tk; m_tleft <= tl; m_wait <= w;
    m_new <= nw;
    if (rst) m_valid <= 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m.level", int'(level), m_level);
      chk("m.timeLeft", int'(timeLeft), m_tleft);
      chk("m.playing", int'(playing), int'(m_ph == M_PLAY));
      chk("m.gameOver", int'(gameOver), int'(m_ph == M_OVER));
      chk("m.win", int'(win), int'(m_ph == M_WIN));
      chk("m.levelComplete", int'(levelComplete), int'(m_ph == M_JUDGE));
      chk("m.newLevel", int'(newLevel), int'(m_new));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pass_level();
    roundDone = 1'b1; cyc(1); roundDone = 1'b0;
    chk("pass.lc", int'(levelComplete), 1);
    cyc(1);
    incLevel = 1'b1; cyc(1); incLevel = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; roundDone = 1'b0; incLevel = 1'b0; lose = 1'b0;
    cyc(2);
    chk("rst.level", int'(level), 1);
    chk("rst.timeLeft", int'(timeLeft), 3);
    chk("rst.flags", int'({playing, gameOver, win, newLevel, levelComplete}), 0);
    rst = 1'b0;

    // Timer expiry from level 1
    start = 1'b1; cyc(1); start = 1'b0;
    chk("start.newLevel", int'(newLevel), 1);
    chk("start.playing", int'(playing), 1);
    chk("start.timeLeft", int'(timeLeft), 3);
    cyc(4); chk("tick.t2", int'(timeLeft), 2);
    cyc(4); chk("tick.t1", int'(timeLeft), 1);
    cyc(4);
    chk("expire.gameOver", int'(gameOver), 1);
    chk("expire.timeLeft", int'(timeLeft), 0);
    chk("expire.lc", int'(levelComplete), 0);
    cyc(2); chk("over.hold", int'({gameOver, timeLeft}), 64);

    // Restart from GAMEOVER
    start = 1'b1; cyc(1); start = 1'b0;
    chk("restart.playing", int'(playing), 1);
    chk("restart.level", int'(level), 1);
    chk("restart.newLevel", int'(newLevel), 1);
    cyc(1); chk("restart.pulse_end", int'(newLevel), 0);

    // Advance through all levels to WIN
    pass_level();
    chk("adv.level2", int'(level), 2);
    chk("adv.timeLeft", int'(timeLeft), 3);
    chk("adv.newLevel", int'(newLevel), 1);
    pass_level();
    chk("adv.level3", int'(level), 3);
    pass_level();
    chk("win.win", int'(win), 1);
    chk("win.level", int'(level), 3);
    chk("win.playing", int'(playing), 0);

    // Verdict timeout retry; incLevel ignored in PLAY
    start = 1'b1; cyc(1); start = 1'b0;
    incLevel = 1'b1; cyc(2); incLevel = 1'b0;
    chk("ignore.level", int'(level), 1);
    roundDone = 1'b1; cyc(1); roundDone = 1'b0;
    chk("retry.lc", int'(levelComplete), 1);
    cyc(4); chk("retry.waiting", int'(playing), 0);
    cyc(1);
    chk("retry.playing", int'(playing), 1);
    chk("retry.newLevel", int'(newLevel), 1);
    chk("retry.level", int'(level), 1);
    chk("retry.timeLeft", int'(timeLeft), 3);

    // roundDone on the final tick; lose beats incLevel
    pass_level();
    chk("final.level2", int'(level), 2);
    cyc(11); chk("final.t1", int'(timeLeft), 1);
    roundDone = 1'b1; cyc(1); roundDone = 1'b0;
    chk("final.lc", int'(levelComplete), 1);
    chk("final.noOver", int'(gameOver), 0);
    chk("final.frozen", int'(timeLeft), 1);
    cyc(1);
    lose = 1'b1; incLevel = 1'b1; cyc(1); lose = 1'b0; incLevel = 1'b0;
    chk("lose.gameOver", int'(gameOver), 1);
    chk("lose.level", int'(level), 2);

    // Reset in WAIT with a pending pass verdict
    start = 1'b1; cyc(1); start = 1'b0;
    pass_level();
    roundDone = 1'b1; cyc(1); roundDone = 1'b0;
    cyc(1);
    rst = 1'b1; incLevel = 1'b1; cyc(1); rst = 1'b0; incLevel = 1'b0;
    chk("wrst.level", int'(level), 1);
    chk("wrst.timeLeft", int'(timeLeft), 3);
    chk("wrst.flags", int'({playing, gameOver, win, newLevel, levelComplete}), 0);
    cyc(2); chk("wrst.idle", int'(playing), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
